// File: rtl/load_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// load_scoreboard_pkg
// Purpose : Shared opcode constants and the decoded register-usage record used
//           by the load scoreboard and by the forwarding selects.
// Contents: OPC_* opcode constants (RV32 base opcode map), reg_use_t.
// -----------------------------------------------------------------------------
package load_scoreboard_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Register fields of one instruction plus which of them are live.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_written;
        logic       is_load;
    } reg_use_t;

endpackage

// File: rtl/load_scoreboard_if.sv
// -----------------------------------------------------------------------------
// load_scoreboard_if
// Purpose : Bundles the ID-side and memory-response signals of the load
//           scoreboard.
// Signals : id_inst/id_valid/id_stall  - instruction in ID and its hold request
//           ld_resp_valid              - memory returns the oldest load
//           ld_wb_valid/ld_wb_rd       - tracked load retiring and its rd
//           ld_count                   - outstanding loads
//           ld_err                     - sticky response-while-empty flag
// Modports: master = pipeline/memory side, slave = scoreboard.
//
// Handshake: an instruction in ID issues on a rising edge where
// id_valid && !id_stall; otherwise it must be held unchanged. ld_resp_valid
// is a one-cycle, unconditionally accepted pulse; ld_wb_valid/ld_wb_rd answer
// it in the same cycle.
// -----------------------------------------------------------------------------
interface load_scoreboard_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      id_inst;
    logic             id_valid;
    logic             id_stall;
    logic             ld_resp_valid;
    logic             ld_wb_valid;
    logic [4:0]       ld_wb_rd;
    logic [CNT_W-1:0] ld_count;
    logic             ld_err;

    modport master (
        output id_inst, id_valid, ld_resp_valid,
        input  id_stall, ld_wb_valid, ld_wb_rd, ld_count, ld_err
    );

    modport slave (
        input  id_inst, id_valid, ld_resp_valid,
        output id_stall, ld_wb_valid, ld_wb_rd, ld_count, ld_err
    );

endinterface

// File: rtl/inst_reg_use.sv
// -----------------------------------------------------------------------------
// inst_reg_use
// Purpose : Purely combinational decode of an instruction into its register
//           fields and the flags saying which are read or written.
// Ports   : inst_i [31:0]  instruction word
//           use_o          reg_use_t {rs1, rs2, rd, rs1_used, rs2_used,
//                                     rd_written, is_load}
// -----------------------------------------------------------------------------
module inst_reg_use
    import load_scoreboard_pkg::*;
(
    input  logic [31:0] inst_i,
    output reg_use_t    use_o
);

    logic [6:0] opc;
    logic       unused_bits;

    assign opc = inst_i[6:0];
    // funct7 and the low funct3 bits do not affect register usage.
    assign unused_bits = ^{inst_i[31:25], inst_i[13:12]};

    always_comb begin
        use_o          = '0;
        use_o.rs1      = inst_i[19:15];
        use_o.rs2      = inst_i[24:20];
        use_o.rd       = inst_i[11:7];
        // Immediate CSR forms (funct3[2]=1) carry a zimm in the rs1 field.
        use_o.rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
                           ((opc == OPC_SYSTEM) && inst_i[14]));
        use_o.rs2_used = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
        use_o.rd_written = !((opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_SYSTEM)) &&
                           (inst_i[11:7] != 5'd0);
        use_o.is_load  = (opc == OPC_LOAD);
    end

endmodule

// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
// Purpose : Tracks the rd of every issued load whose data has not returned
//           from variable-latency data memory, stalls ID on RAW/WAW conflicts
//           with those loads, and announces each returning load's rd.
// Ports   : clk    core clock, rising edge
//           rst_n  asynchronous active-low reset
//           sb     load_scoreboard_if.slave (see interface for signal list)
// Params  : DEPTH  maximum outstanding loads (power of two, 2..16)
//           CNT_W  width of the occupancy count
// -----------------------------------------------------------------------------
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_scoreboard_if.slave     sb
);

    localparam int PTR_W = $clog2(DEPTH);

    reg_use_t         dec;
    logic [4:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             err_q,    err_d;

    logic [DEPTH-1:0] entry_valid;
    logic             full, empty;
    logic             hit_rs1, hit_rs2, hit_rd;
    logic             stall, push, pop;

    inst_reg_use u_dec (
        .inst_i (sb.id_inst),
        .use_o  (dec)
    );

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // An entry is live when its distance from the read pointer is below the
    // occupancy count.
    always_comb begin
        logic [PTR_W-1:0] off;
        entry_valid = '0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, off} < count_q);
        end
    end

    // The head entry still matches in the cycle it pops: no same-cycle bypass.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                if ((dec.rs1 != 5'd0) && (fifo_q[i] == dec.rs1)) hit_rs1 = 1'b1;
                if ((dec.rs2 != 5'd0) && (fifo_q[i] == dec.rs2)) hit_rs2 = 1'b1;
                if ((dec.rd  != 5'd0) && (fifo_q[i] == dec.rd))  hit_rd  = 1'b1;
            end
        end
    end

    // Full stalls a load regardless of a same-cycle pop.
    assign stall = sb.id_valid &&
                   ((dec.rs1_used && hit_rs1) || (dec.rs2_used && hit_rs2) ||
                    (dec.rd_written && hit_rd) || (dec.is_load && full));

    // Loads to x0 issue but are not tracked.
    assign push = sb.id_valid && !stall && dec.is_load && (dec.rd != 5'd0);
    assign pop  = sb.ld_resp_valid && !empty;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        err_d    = err_q || (sb.ld_resp_valid && empty);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= dec.rd;
        end
    end

    assign sb.id_stall    = stall;
    assign sb.ld_wb_valid = pop;
    assign sb.ld_wb_rd    = pop ? fifo_q[rd_ptr_q] : 5'd0;
    assign sb.ld_count    = count_q;
    assign sb.ld_err      = err_q;

endmodule
